// File: rtl/decode_stage.sv
// RV32I/RV64 instruction decode stage: combinational decoder feeding a single
// valid/ready pipeline register, plus a saturating illegal-instruction counter.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter bit RV64  = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [3:0]       out_alu_op,
    output logic             out_alu_src,
    output logic             out_alu_pc,
    output logic             out_branch_enable,
    output logic [2:0]       out_branch_cond,
    output logic             out_jump,
    output logic             out_jalr,
    output logic             out_mem_read,
    output logic             out_mem_write_enable,
    output logic [1:0]       out_mem_size,
    output logic             out_mem_unsigned,
    output logic             out_mem_to_reg,
    output logic             out_reg_write_enable,
    output logic             out_ill_instr,
    output logic [CNT_W-1:0] ill_count
);

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_1 = 4'd10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        shl_ok, shr_ok;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // With a 64-bit datapath, bit 25 is shamt[5] rather than part of funct7.
    generate
        if (XLEN == 64) begin : g_shamt6
            assign shl_ok = (funct7[6:1] == 6'b000000);
            assign shr_ok = (funct7[6:1] == 6'b000000) || (funct7[6:1] == 6'b010000);
        end else begin : g_shamt5
            assign shl_ok = (funct7 == 7'b0000000);
            assign shr_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end
    endgenerate

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_of = ALU_SLL;
            3'd2:    alu_of = ALU_SLT;
            3'd3:    alu_of = ALU_SLTU;
            3'd4:    alu_of = ALU_XOR;
            3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    logic [31:0] d_imm32;
    logic [3:0]  d_alu_op;
    logic        d_alu_src, d_alu_pc, d_branch, d_jump, d_jalr;
    logic        d_mem_read, d_mem_write, d_mem_unsigned, d_mem_to_reg, d_reg_write, d_ill;
    logic [1:0]  d_mem_size;

    always_comb begin
        d_imm32        = imm_i;
        d_alu_op       = ALU_ADD;
        d_alu_src      = 1'b0;
        d_alu_pc       = 1'b0;
        d_branch       = 1'b0;
        d_jump         = 1'b0;
        d_jalr         = 1'b0;
        d_mem_read     = 1'b0;
        d_mem_write    = 1'b0;
        d_mem_size     = 2'd0;
        d_mem_unsigned = 1'b0;
        d_mem_to_reg   = 1'b0;
        d_reg_write    = 1'b0;
        d_ill          = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_alu_op    = ALU_PASS_1;
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                d_imm32     = imm_u;
            end
            OPC_AUIPC: begin
                d_alu_src   = 1'b1;
                d_alu_pc    = 1'b1;
                d_reg_write = 1'b1;
                d_imm32     = imm_u;
            end
            OPC_JAL: begin
                d_alu_src   = 1'b1;
                d_alu_pc    = 1'b1;
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
                d_imm32     = imm_j;
            end
            OPC_JALR: begin
                d_alu_src   = 1'b1;
                d_jump      = 1'b1;
                d_jalr      = 1'b1;
                d_reg_write = 1'b1;
                d_ill       = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                d_alu_op = ALU_SUB;
                d_branch = 1'b1;
                d_imm32  = imm_b;
                d_ill    = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_LOAD: begin
                d_alu_src      = 1'b1;
                d_mem_read     = 1'b1;
                d_mem_to_reg   = 1'b1;
                d_reg_write    = 1'b1;
                d_mem_size     = funct3[1:0];
                d_mem_unsigned = funct3[2];
                case (funct3)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: d_ill = 1'b0;
                    3'd3, 3'd6:                   d_ill = !RV64;
                    default:                      d_ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
                d_mem_size  = funct3[1:0];
                d_imm32     = imm_s;
                case (funct3)
                    3'd0, 3'd1, 3'd2: d_ill = 1'b0;
                    3'd3:             d_ill = !RV64;
                    default:          d_ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                d_alu_op    = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
                d_ill       = ((funct3 == 3'd1) && !shl_ok) || ((funct3 == 3'd5) && !shr_ok);
            end
            OPC_OP: begin
                d_reg_write = 1'b1;
                d_alu_op    = alu_of(funct3, funct7[5]);
                d_ill       = !((funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
            end
            default: d_ill = 1'b1;
        endcase
        // An unrecognised instruction must not have any architectural side effect.
        if (d_ill) begin
            d_branch     = 1'b0;
            d_jump       = 1'b0;
            d_jalr       = 1'b0;
            d_mem_read   = 1'b0;
            d_mem_write  = 1'b0;
            d_mem_to_reg = 1'b0;
            d_reg_write  = 1'b0;
        end
    end

    logic transfer;
    assign in_ready = !out_valid || out_ready;
    assign transfer = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid            <= 1'b0;
            out_pc               <= '0;
            out_rd               <= '0;
            out_rs1              <= '0;
            out_rs2              <= '0;
            out_imm              <= '0;
            out_alu_op           <= '0;
            out_alu_src          <= 1'b0;
            out_alu_pc           <= 1'b0;
            out_branch_enable    <= 1'b0;
            out_branch_cond      <= '0;
            out_jump             <= 1'b0;
            out_jalr             <= 1'b0;
            out_mem_read         <= 1'b0;
            out_mem_write_enable <= 1'b0;
            out_mem_size         <= '0;
            out_mem_unsigned     <= 1'b0;
            out_mem_to_reg       <= 1'b0;
            out_reg_write_enable <= 1'b0;
            out_ill_instr        <= 1'b0;
            ill_count            <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (transfer) begin
                out_valid            <= 1'b1;
                out_pc               <= in_pc;
                out_rd               <= in_instr[11:7];
                out_rs1              <= in_instr[19:15];
                out_rs2              <= in_instr[24:20];
                out_imm              <= XLEN'($signed(d_imm32));
                out_alu_op           <= d_alu_op;
                out_alu_src          <= d_alu_src;
                out_alu_pc           <= d_alu_pc;
                out_branch_enable    <= d_branch;
                out_branch_cond      <= funct3;
                out_jump             <= d_jump;
                out_jalr             <= d_jalr;
                out_mem_read         <= d_mem_read;
                out_mem_write_enable <= d_mem_write;
                out_mem_size         <= d_mem_size;
                out_mem_unsigned     <= d_mem_unsigned;
                out_mem_to_reg       <= d_mem_to_reg;
                out_reg_write_enable <= d_reg_write;
                out_ill_instr        <= d_ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready && out_ill_instr && (ill_count != '1)) begin
                ill_count <= ill_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed checks of decode_stage against a mnemonic-level
// reference decoder, using an expected-bundle queue drained by a monitor.
module tb_decode_stage;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                           A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                           A_OR = 4'd8, A_AND = 4'd9, A_PASS_1 = 4'd10;
    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_alu_op;
    logic        out_alu_src, out_alu_pc, out_branch_enable, out_jump, out_jalr;
    logic [2:0]  out_branch_cond;
    logic        out_mem_read, out_mem_write_enable, out_mem_unsigned;
    logic        out_mem_to_reg, out_reg_write_enable, out_ill_instr;
    logic [1:0]  out_mem_size;
    logic [1:0]  ill_count;

    decode_stage #(.XLEN(32), .RV64(1'b0), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_alu_op(out_alu_op),
        .out_alu_src(out_alu_src), .out_alu_pc(out_alu_pc),
        .out_branch_enable(out_branch_enable), .out_branch_cond(out_branch_cond),
        .out_jump(out_jump), .out_jalr(out_jalr), .out_mem_read(out_mem_read),
        .out_mem_write_enable(out_mem_write_enable), .out_mem_size(out_mem_size),
        .out_mem_unsigned(out_mem_unsigned), .out_mem_to_reg(out_mem_to_reg),
        .out_reg_write_enable(out_reg_write_enable), .out_ill_instr(out_ill_instr),
        .ill_count(ill_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        chk_imm;
        logic [3:0]  alu_op;
        logic        chk_alu, alu_src, alu_pc;
        logic        br;
        logic [2:0]  cond;
        logic        jump, jalr, mr, mw;
        logic [1:0]  msize;
        logic        muns, chk_mem, m2r, rw, ill;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t pend;
    int   checks = 0;
    int   errors = 0;
    int   ill_model = 0;
    logic [3:0] alu_by_f3 [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: classify by mnemonic, then build immediates arithmetically.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int si, imm_i, imm_s, imm_b, imm_u, imm_j, f3, f7;
        si    = $signed(w);
        f3    = int'(w[14:12]);
        f7    = int'(w[31:25]);
        imm_i = si >>> 20;
        imm_s = (si >>> 25) * 32 + int'(w[11:7]);
        imm_b = (si >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        imm_u = (si >>> 12) * 4096;
        imm_j = (si >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        e = '{pc: pc, rd: w[11:7], rs1: w[19:15], rs2: w[24:20], imm: 32'd0, chk_imm: 1'b1,
              alu_op: A_ADD, chk_alu: 1'b1, alu_src: 1'b0, alu_pc: 1'b0, br: 1'b0,
              cond: w[14:12], jump: 1'b0, jalr: 1'b0, mr: 1'b0, mw: 1'b0, msize: 2'd0,
              muns: 1'b0, chk_mem: 1'b0, m2r: 1'b0, rw: 1'b0, ill: 1'b0};
        case (w[6:0])
            7'h37: begin e.imm = imm_u; e.alu_op = A_PASS_1; e.alu_src = 1; e.rw = 1; end
            7'h17: begin e.imm = imm_u; e.alu_src = 1; e.alu_pc = 1; e.rw = 1; end
            7'h6F: begin e.imm = imm_j; e.alu_src = 1; e.alu_pc = 1; e.jump = 1; e.rw = 1; end
            7'h67: if (f3 == 0) begin
                       e.imm = imm_i; e.alu_src = 1; e.jump = 1; e.jalr = 1; e.rw = 1;
                   end else e.ill = 1;
            7'h63: if (f3 != 2 && f3 != 3) begin
                       e.imm = imm_b; e.alu_op = A_SUB; e.br = 1;
                   end else e.ill = 1;
            7'h03: if (f3 inside {0, 1, 2, 4, 5}) begin
                       e.imm = imm_i; e.alu_src = 1; e.mr = 1; e.m2r = 1; e.rw = 1;
                       e.chk_mem = 1; e.msize = 2'(f3 % 4); e.muns = (f3 >= 4);
                   end else e.ill = 1;
            7'h23: if (f3 <= 2) begin
                       e.imm = imm_s; e.alu_src = 1; e.mw = 1; e.chk_mem = 1; e.msize = 2'(f3);
                   end else e.ill = 1;
            7'h13: if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32)) e.ill = 1;
                   else begin
                       e.imm = imm_i; e.alu_src = 1; e.rw = 1;
                       e.alu_op = (f3 == 5 && f7 == 32) ? A_SRA : alu_by_f3[f3];
                   end
            7'h33: begin
                       e.chk_imm = 0;
                       if (f7 == 0) begin e.alu_op = alu_by_f3[f3]; e.rw = 1; end
                       else if (f7 == 32 && f3 == 0) begin e.alu_op = A_SUB; e.rw = 1; end
                       else if (f7 == 32 && f3 == 5) begin e.alu_op = A_SRA; e.rw = 1; end
                       else e.ill = 1;
                   end
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.chk_imm = 0; e.chk_alu = 0; e.chk_mem = 0; end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] w;
        int k, r;
        w = $urandom();
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = opcs[k];
        r = $urandom_range(0, 3);
        if (r < 2) w[31:25] = 7'h00;
        else if (r == 2) w[31:25] = 7'h20;
        return w;
    endfunction

    // Issuer: record the expected bundle for every accepted instruction.
    always begin
        @(negedge clk);
        if (rst_n && in_valid && in_ready && !flush) begin
            pend = ref_decode(in_instr, in_pc);
            @(posedge clk);
            if (rst_n) q.push_back(pend);
        end
    end

    // Monitor: the queue head is the bundle the stage should be presenting.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, (q.size() == 0) || out_ready);
            chk("out_valid", out_valid, q.size() != 0);
            chk("ill_count", ill_count, ill_model);
            if (q.size() != 0) begin
                mon_e = q[0];
                chk("pc", out_pc, mon_e.pc);
                chk("rd", out_rd, mon_e.rd);
                chk("rs1", out_rs1, mon_e.rs1);
                chk("rs2", out_rs2, mon_e.rs2);
                if (mon_e.chk_imm) chk("imm", out_imm, mon_e.imm);
                if (mon_e.chk_alu) begin
                    chk("alu_op", out_alu_op, mon_e.alu_op);
                    chk("alu_src", out_alu_src, mon_e.alu_src);
                    chk("alu_pc", out_alu_pc, mon_e.alu_pc);
                end
                if (mon_e.br) chk("branch_cond", out_branch_cond, mon_e.cond);
                if (mon_e.chk_mem) begin
                    chk("mem_size", out_mem_size, mon_e.msize);
                    chk("mem_unsigned", out_mem_unsigned, mon_e.muns);
                end
                chk("branch_enable", out_branch_enable, mon_e.br);
                chk("jump", out_jump, mon_e.jump);
                chk("jalr", out_jalr, mon_e.jalr);
                chk("mem_read", out_mem_read, mon_e.mr);
                chk("mem_write", out_mem_write_enable, mon_e.mw);
                chk("mem_to_reg", out_mem_to_reg, mon_e.m2r);
                chk("reg_write", out_reg_write_enable, mon_e.rw);
                chk("ill_instr", out_ill_instr, mon_e.ill);
                if (out_ready && mon_e.ill && ill_model != CNT_MAX) ill_model++;
                if (out_ready || flush) void'(q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f);
        in_valid  = v;
        in_instr  = w;
        out_ready = r;
        flush     = f;
        in_pc     = $urandom() & 32'hFFFF_FFFC;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream [4] = '{32'h00412083, 32'h00312423, 32'h010000EF, 32'h00008067};

    initial begin
        rst_n = 1'b0;
        drive(0, 32'd0, 0, 0);
        in_pc = 32'd0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ill_count", ill_count, 0);
        chk("rst_reg_write", out_reg_write_enable, 0);
        chk("rst_imm", out_imm, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // addi x5,x1,-3
        drive(1, 32'hFFD08293, 1, 0);
        step();
        drive(0, 32'd0, 1, 0);
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", out_rd, 5);
        chk("addi_rs1", out_rs1, 1);
        chk("addi_imm", out_imm, 32'hFFFFFFFD);
        chk("addi_alu", out_alu_op, A_ADD);
        chk("addi_src", out_alu_src, 1);
        chk("addi_rw", out_reg_write_enable, 1);
        step();

        // bne x1,x2,-8 held for three cycles while another instruction waits
        drive(1, 32'hFE209CE3, 0, 0);
        step();
        drive(1, 32'h00000013, 0, 0);
        repeat (3) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_cond", out_branch_cond, 1);
            chk("stall_imm", out_imm, 32'hFFFFFFF8);
            step();
        end
        drive(0, 32'd0, 1, 0);
        step();

        // back-to-back stream: lw, sw, jal, jalr
        for (int i = 0; i < 4; i++) begin
            drive(1, stream[i], 1, 0);
            step();
            chk("stream_valid", out_valid, 1);
            if (i < 2) chk("stream_mem_size", out_mem_size, 2);
            if (i == 2) begin
                chk("jal_jump", out_jump, 1);
                chk("jal_alu_pc", out_alu_pc, 1);
            end
            if (i == 3) chk("jalr_flag", out_jalr, 1);
        end
        drive(0, 32'd0, 1, 0);
        step();
        chk("stream_drained", out_valid, 0);

        // fence then ld (illegal without RV64)
        drive(1, 32'h0000000F, 1, 0);
        step();
        chk("fence_ill", out_ill_instr, 1);
        chk("fence_rw", out_reg_write_enable, 0);
        drive(1, 32'h0000B183, 1, 0);
        step();
        chk("ld_ill", out_ill_instr, 1);
        chk("ld_mem_read", out_mem_read, 0);
        chk("ld_rw", out_reg_write_enable, 0);
        drive(0, 32'd0, 1, 0);
        step();
        chk("ill_count_two", ill_count, 2);

        // flush wins over a simultaneous transfer
        drive(1, 32'hFFD08293, 1, 0);
        step();
        drive(1, 32'h00500113, 1, 1);
        step();
        chk("flush_valid", out_valid, 0);
        drive(0, 32'd0, 1, 0);
        step();

        // saturate the counter, then async reset with a bundle held
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h00000073, 1, 0);
            step();
        end
        drive(0, 32'd0, 1, 0);
        step();
        chk("ill_count_sat", ill_count, CNT_MAX);
        drive(1, 32'hFFD08293, 0, 0);
        step();
        drive(0, 32'd0, 0, 0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_ill_count", ill_count, 0);
        chk("async_in_ready", in_ready, 1);
        q.delete();
        ill_model = 0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_valid", out_valid, 0);

        // randomised traffic
        repeat (3000) begin
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
            step();
        end
        drive(0, 32'd0, 1, 0);
        repeat (5) step();
        chk("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
